store_buffer: RTL
=================

Name: store_buffer

Overview:
- Sits directly downstream of the MEM-stage byte-enable generator.
- Accepts stores as {word address, lane-aligned write data, 4-bit byte enable} and queues them in a small in-order FIFO.
- Drains the queue to the data-memory bus with a req/ack handshake.
- Flags loads that overlap a pending store so the pipeline can stall the load until the store has drained.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- AW, 32, address width; bits [1:0] are ignored and word address = addr[AW-1:2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- st_valid  in  1  MEM stage presents a store this cycle.
- st_addr  in  AW  store byte address.
- st_wdata  in  32  write data, already placed on the correct byte lanes.
- st_be  in  4  byte enable from the MEM stage (1111, 0011, 1100, 0001, 0010, 0100, 1000, or 0000).
- st_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  MEM stage presents a load this cycle.
- ld_addr  in  AW  load byte address.
- ld_be  in  4  lanes the load reads.
- ld_hazard  out  1  load overlaps a pending store.
- bus_req  out  1  head entry is presented to memory.
- bus_addr  out  AW  head word address, with bits [1:0] driven as 00.
- bus_wdata  out  32  head data.
- bus_be  out  4  head byte enable.
- bus_ack  in  1  memory accepted the head entry this cycle.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Pointers, count and all entry valid bits clear immediately.
  - bus_req=0, ld_hazard=0, st_ready=1, bus_addr/bus_wdata/bus_be=0.
  - A reset asserted mid-handshake discards every queued store; the bus must treat bus_req falling as an abort.
- Push:
  - Occurs when st_valid && st_ready && st_be!=0.
  - The entry is written at the tail; count increments at the next edge.
  - st_valid with st_be==0 is a no-op: accepted, not queued.
- st_ready = (count<DEPTH). It is combinational from registered count only. There is no pass-through when full: a push and a pop in the same cycle while full is impossible, because ready is low.
- Drain:
  - bus_req = (count!=0).
  - bus_addr/bus_wdata/bus_be come from the head entry and hold stable while bus_req && !bus_ack.
  - On bus_ack && bus_req, the head pops at the edge.
  - bus_ack while bus_req=0 is ignored.
- Push and pop in the same cycle (not full, not empty): count is unchanged and both pointers advance.
- Latency:
  - A store pushed at edge N is visible on the bus at cycle N+1 at the earliest, when the queue was empty.
  - An acked entry is gone at N+1.
- Pointers wrap modulo DEPTH. Count saturates logically at DEPTH because st_ready is low when full.
- Ordering: strict FIFO. The bus sees stores in acceptance order.
- ld_hazard:
  - Combinational: ld_valid && there exists a valid entry i with entry_word==ld_addr[AW-1:2] and (entry_be & ld_be)!=0.
  - An entry being acked in the current cycle still counts as pending.
  - A store being pushed in the same cycle is not included; the pipeline orders the store before the load.

Optional Feature:
- Macro: STORE_BUFFER_MERGE_EN.
- Defined:
  - A push whose word address equals the youngest valid entry, where that entry is not the head currently presented with bus_req, merges into that entry instead of allocating a new one.
  - Merge: be |= st_be; for each set st_be lane, the data lane is replaced.
  - Count is unchanged.
  - A merge is allowed even when full, so st_ready = !full || merge_hit.
- Undefined: every push allocates; st_ready = !full.

Decomposition:
- Shared package store_buffer_pkg holds:
  - BE width 4, data width 32.
  - The entry typedef {valid, word_addr, wdata, be}.
  - The BE lane constants (BE_WORD=1111, BE_HALF_LO=0011, BE_HALF_HI=1100, BE_BYTE0..3).
- One sub-module, store_buffer_cam: takes the entry array and the load word address and lanes, and returns the overlap match. It is purely combinational and reused for the merge-hit check.

Test Plan:
- Reset with 3 entries queued and bus_req high -> bus_req=0, count=0 and st_ready=1 immediately, before the next clock edge.
- Push 0x10/0xAABBCCDD/1111, then 0x14/0x0000EE00/0010 while bus_ack=0 -> count=2 and bus holds 0x10/0xAABBCCDD/1111. After ack -> bus shows 0x14/be 0010 and count=1.
- Fill DEPTH=4 entries with no ack -> st_ready=0. A fifth st_valid is not queued and count stays 4. With one ack, st_ready=1 the next cycle.
- Pending sh at 0x20, be=1100 -> lb at 0x21 (ld_be=0010) gives ld_hazard=0; lh at 0x22 (ld_be=1100) gives ld_hazard=1; lw at 0x24 gives ld_hazard=0.
- Push and ack in the same cycle with count=2 -> count stays 2 and the bus order is preserved across pointer wrap (8 stores through DEPTH=4).
- With STORE_BUFFER_MERGE_EN: head at 0x30 is stalled; push sb 0x34 be 0001 data 0x11, then sb 0x35 be 0010 data 0x2200 -> count=2 and the second entry is be 0011, data 0x00002211.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: entry layout, lane widths and byte-enable encodings.
// Word addresses are held at the 32-bit-address width; narrower AW zero-extends into it.
package store_buffer_pkg;

    localparam int unsigned BE_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORD_W = 30;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic              valid;
        word_t             word_addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } sb_entry_t;

    localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;
    localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
    localparam logic [BE_W-1:0] BE_BYTE1   = 4'b0010;
    localparam logic [BE_W-1:0] BE_BYTE2   = 4'b0100;
    localparam logic [BE_W-1:0] BE_BYTE3   = 4'b1000;

    // Replace each byte lane of old_data whose enable is set with the lane from new_data.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] new_data,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] result;
        result = old_data;
        for (int unsigned lane = 0; lane < BE_W; lane++) begin
            if (be[lane]) begin
                result[8*lane +: 8] = new_data[8*lane +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store, load-probe and memory-bus signals of the store buffer.
// slave: the buffer itself; master: the MEM stage and memory side driving it.
interface store_buffer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
);
    import store_buffer_pkg::*;

    logic                   st_valid;
    logic [AW-1:0]          st_addr;
    logic [DATA_W-1:0]      st_wdata;
    logic [BE_W-1:0]        st_be;
    logic                   st_ready;

    logic                   ld_valid;
    logic [AW-1:0]          ld_addr;
    logic [BE_W-1:0]        ld_be;
    logic                   ld_hazard;

    logic                   bus_req;
    logic [AW-1:0]          bus_addr;
    logic [DATA_W-1:0]      bus_wdata;
    logic [BE_W-1:0]        bus_be;
    logic                   bus_ack;

    logic [$clog2(DEPTH):0] count;

    modport slave (
        input  st_valid, st_addr, st_wdata, st_be,
        output st_ready,
        input  ld_valid, ld_addr, ld_be,
        output ld_hazard,
        output bus_req, bus_addr, bus_wdata, bus_be,
        input  bus_ack,
        output count
    );

    modport master (
        output st_valid, st_addr, st_wdata, st_be,
        input  st_ready,
        output ld_valid, ld_addr, ld_be,
        input  ld_hazard,
        input  bus_req, bus_addr, bus_wdata, bus_be,
        output bus_ack,
        input  count
    );

endinterface

// File: rtl/store_buffer_cam.sv
// Combinational overlap match of a word address + lane mask against every valid entry.
// Used for the load hazard and, when merging is built in, for the merge-hit probe.
module store_buffer_cam
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  sb_entry_t       entries [DEPTH],
    input  word_t           word,
    input  logic [BE_W-1:0] be,
    output logic [DEPTH-1:0] hits
);

    always_comb begin
        hits = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hits[i] = entries[i].valid
                   && (entries[i].word_addr == word)
                   && ((entries[i].be & be) != '0);
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store queue draining to the data-memory bus with load-overlap detection.
// Optional macro STORE_BUFFER_MERGE_EN merges pushes into the youngest non-head entry.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    store_buffer_if.slave sb
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t        entries [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;

    logic             full;
    logic             empty;
    logic [PW-1:0]    youngest;
    word_t            st_word;
    word_t            ld_word;
    logic [DEPTH-1:0] ld_hits;
    logic             merge_hit;
    logic             push_ok;
    logic             alloc;
    logic             pop;
    logic             unused_addr_bits;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign youngest = tail - PW'(1);
    assign st_word  = word_t'(sb.st_addr[AW-1:2]);
    assign ld_word  = word_t'(sb.ld_addr[AW-1:2]);

    assign unused_addr_bits = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

    store_buffer_cam #(.DEPTH(DEPTH)) u_ld_cam (
        .entries (entries),
        .word    (ld_word),
        .be      (sb.ld_be),
        .hits    (ld_hits)
    );

`ifdef STORE_BUFFER_MERGE_EN
    logic [DEPTH-1:0] mg_hits;

    // Probing with all lanes set turns the overlap CAM into a plain word-address match.
    store_buffer_cam #(.DEPTH(DEPTH)) u_mg_cam (
        .entries (entries),
        .word    (st_word),
        .be      (BE_WORD),
        .hits    (mg_hits)
    );

    // With a single entry the youngest is the head on the bus, which must stay stable.
    assign merge_hit   = (cnt > CW'(1)) && mg_hits[youngest];
    assign sb.st_ready = !full || merge_hit;
`else
    assign merge_hit   = 1'b0;
    assign sb.st_ready = !full;
`endif

    assign push_ok = sb.st_valid && sb.st_ready && (sb.st_be != '0);
    assign alloc   = push_ok && !merge_hit;
    assign pop     = sb.bus_req && sb.bus_ack;

    assign sb.ld_hazard = sb.ld_valid && (ld_hits != '0);
    assign sb.count     = cnt;
    assign sb.bus_req   = !empty;
    assign sb.bus_addr  = empty ? '0 : {entries[head].word_addr[AW-3:0], 2'b00};
    assign sb.bus_wdata = empty ? '0 : entries[head].wdata;
    assign sb.bus_be    = empty ? '0 : entries[head].be;

    // Alloc/pop never hit the same slot (that needs empty or full); a merge never targets the head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (alloc) begin
                entries[tail] <= '{valid:     1'b1,
                                   word_addr: st_word,
                                   wdata:     sb.st_wdata,
                                   be:        sb.st_be};
                tail <= tail + PW'(1);
            end
`ifdef STORE_BUFFER_MERGE_EN
            if (push_ok && merge_hit) begin
                entries[youngest].be    <= entries[youngest].be | sb.st_be;
                entries[youngest].wdata <= merge_lanes(entries[youngest].wdata,
                                                       sb.st_wdata, sb.st_be);
            end
`endif
            if (pop) begin
                entries[head].valid <= 1'b0;
                head <= head + PW'(1);
            end
            unique case ({alloc, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule
